// File: rtl/core_seq.sv
// Autonomous instruction sequencer for the systolic core: walks weight load,
// activation streaming, execution and psum drain, emitting one 36-bit word per cycle.
module core_seq #(
    parameter int row = 8,
    parameter int col = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic        relu,
    input  logic [3:0]  n_kij,
    input  logic [10:0] n_act,
    input  logic [10:0] w_base,
    input  logic [10:0] x_base,
    input  logic [10:0] p_base,
    input  logic        ofifo_valid,
    output logic [35:0] inst,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, W_RD, W_LD, W_FL, X_RD, EXEC, DRAIN, DONE} state_t;

    localparam logic [35:0] IDLE_W   = 36'h1_800C_0000;
    localparam logic [10:0] COL_N    = 11'(col);
    localparam logic [10:0] COL_LAST = 11'(col - 1);
    localparam logic [10:0] FL_LAST  = 11'(row + col - 1);

    state_t      state;
    logic [10:0] i, j, w_ptr, x_b, p_b, n_act_l;
    logic [3:0]  k, n_kij_l;
    logic        mode_l, relu_l, rd_pend, wr_cur;

    // xmem read word; wr adds l0_wr for the data returning from the previous read
    function automatic logic [35:0] xword(input logic [10:0] a, input logic rd,
                                          input logic wr, input logic m);
        xword     = IDLE_W;
        xword[35] = m;
        xword[2]  = wr;
        if (rd) begin
            xword[19]   = 1'b0;
            xword[17:7] = a;
        end
    endfunction

    function automatic logic [35:0] cword(input logic [1:0] op, input logic rd, input logic m);
        cword      = IDLE_W;
        cword[35]  = m;
        cword[3]   = rd;
        cword[1:0] = op;
    endfunction

    function automatic logic [35:0] pword(input logic [10:0] a, input logic wr, input logic acc,
                                          input logic rl, input logic m);
        pword       = IDLE_W;
        pword[35]   = m;
        pword[32]   = 1'b0;
        pword[30:20] = a;
        if (wr) begin
            pword[31] = 1'b0;
            pword[6]  = 1'b1;
            pword[33] = acc;
            pword[34] = rl;
        end
    endfunction

    logic        last_k, acc_on, relu_on, iss_rd, iss_wr, pass_end;
    logic [10:0] j_nx, w_nxt;
    logic [35:0] iss_word;

    assign last_k  = (k == n_kij_l - 4'd1);
    assign acc_on  = (k != 4'd0);
    assign relu_on = relu_l & last_k;
    assign w_nxt   = w_ptr + COL_N;
    assign j_nx    = wr_cur ? j + 11'd1 : j;
    // Next drain step: later passes read the old psum first, then write it back.
    assign iss_rd   = ofifo_valid & acc_on;
    assign iss_wr   = ofifo_valid & ~acc_on;
    assign iss_word = ofifo_valid ? pword(p_b + j_nx, ~acc_on, acc_on, relu_on, mode_l) : IDLE_W;
    assign pass_end = mode_l ? (i == FL_LAST) : (!rd_pend && wr_cur && j == n_act_l - 11'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            inst    <= IDLE_W;
            busy    <= 1'b0;
            done    <= 1'b0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            w_ptr   <= '0;
            x_b     <= '0;
            p_b     <= '0;
            n_act_l <= '0;
            n_kij_l <= '0;
            mode_l  <= 1'b0;
            relu_l  <= 1'b0;
            rd_pend <= 1'b0;
            wr_cur  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    inst    <= IDLE_W;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    i       <= '0;
                    j       <= '0;
                    k       <= '0;
                    rd_pend <= 1'b0;
                    wr_cur  <= 1'b0;
                    if (start) begin
                        mode_l  <= mode;
                        relu_l  <= relu;
                        n_kij_l <= n_kij;
                        n_act_l <= n_act;
                        w_ptr   <= w_base;
                        x_b     <= x_base;
                        p_b     <= p_base;
                        busy    <= 1'b1;
                        if (n_kij == 4'd0 || n_act == 11'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (mode) begin
                            state <= X_RD;
                            inst  <= xword(x_base, 1'b1, 1'b0, 1'b1);
                        end else begin
                            state <= W_RD;
                            inst  <= xword(w_base, 1'b1, 1'b0, 1'b0);
                        end
                    end
                end
                W_RD: if (i == COL_N) begin
                    state <= W_LD;
                    i     <= '0;
                    inst  <= cword(2'b01, 1'b1, mode_l);
                end else begin
                    i    <= i + 11'd1;
                    inst <= xword(w_ptr + i + 11'd1, (i + 11'd1) != COL_N, 1'b1, mode_l);
                end
                W_LD: if (i == COL_LAST) begin
                    state <= W_FL;
                    i     <= '0;
                    inst  <= cword(2'b00, 1'b0, mode_l);
                end else begin
                    i    <= i + 11'd1;
                    inst <= cword(2'b01, 1'b1, mode_l);
                end
                W_FL: if (i == FL_LAST) begin
                    state <= X_RD;
                    i     <= '0;
                    inst  <= xword(x_b, 1'b1, 1'b0, mode_l);
                end else begin
                    i    <= i + 11'd1;
                    inst <= cword(2'b00, 1'b0, mode_l);
                end
                X_RD: if (i == n_act_l) begin
                    state   <= EXEC;
                    i       <= '0;
                    j       <= '0;
                    rd_pend <= 1'b0;
                    wr_cur  <= 1'b0;
                    inst    <= cword(2'b10, 1'b1, mode_l);
                end else begin
                    i    <= i + 11'd1;
                    inst <= xword(x_b + i + 11'd1, (i + 11'd1) != n_act_l, 1'b1, mode_l);
                end
                EXEC: if (i == n_act_l - 11'd1) begin
                    state <= DRAIN;
                    i     <= '0;
                    if (mode_l) begin
                        inst <= cword(2'b00, 1'b0, 1'b1);
                    end else begin
                        inst    <= iss_word;
                        rd_pend <= iss_rd;
                        wr_cur  <= iss_wr;
                    end
                end else begin
                    i    <= i + 11'd1;
                    inst <= cword(2'b10, 1'b1, mode_l);
                end
                DRAIN: if (pass_end) begin
                    rd_pend <= 1'b0;
                    wr_cur  <= 1'b0;
                    i       <= '0;
                    j       <= '0;
                    if (last_k) begin
                        state <= DONE;
                        done  <= 1'b1;
                        inst  <= IDLE_W;
                    end else begin
                        k <= k + 4'd1;
                        if (mode_l) begin
                            state <= X_RD;
                            inst  <= xword(x_b, 1'b1, 1'b0, 1'b1);
                        end else begin
                            state <= W_RD;
                            w_ptr <= w_nxt;
                            inst  <= xword(w_nxt, 1'b1, 1'b0, 1'b0);
                        end
                    end
                end else if (mode_l) begin
                    i    <= i + 11'd1;
                    inst <= cword(2'b00, 1'b0, 1'b1);
                end else if (rd_pend) begin
                    // a read is always followed by its write, regardless of ofifo_valid
                    inst    <= pword(p_b + j, 1'b1, 1'b1, relu_on, mode_l);
                    rd_pend <= 1'b0;
                    wr_cur  <= 1'b1;
                end else begin
                    j       <= j_nx;
                    inst    <= iss_word;
                    rd_pend <= iss_rd;
                    wr_cur  <= iss_wr;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    inst  <= IDLE_W;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: a job table expanded into an expected per-cycle word stream
// (scoreboard queue) plus hand-written reset sequences.
module tb_core_seq;
    localparam logic [35:0] IW = 36'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset, start, mode, relu, ofifo_valid;
    logic [3:0]  n_kij;
    logic [10:0] n_act, w_base, x_base, p_base;
    logic [35:0] inst;
    logic        busy, done;

    always #5 clk = ~clk;

    core_seq #(.row(8), .col(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .relu(relu),
        .n_kij(n_kij), .n_act(n_act), .w_base(w_base), .x_base(x_base), .p_base(p_base),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
    );

    typedef struct {
        logic md; logic rl; logic [3:0] nk; logic [10:0] na, wb, xb, pb;
        int sj; int sn; int exp_len;
    } job_t;
    typedef struct { logic [35:0] w; logic ov; logic dn; } exp_t;

    exp_t q[$];
    int   nvec = 0, nerr = 0;
    job_t jobs[8];

    task automatic chk(input string nm, input int t, input logic [35:0] act, input logic [35:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0d got %h want %h", nm, t, act, exp);
        end
    endtask

    // field-level builder: pc/pw = pmem access/write, xr = xmem read
    function automatic logic [35:0] mk(input logic [1:0] op, input logic l0w, input logic l0r,
                                       input logic ofr, input logic [10:0] xa, input logic xr,
                                       input logic [10:0] pa, input logic pc, input logic pw,
                                       input logic acc, input logic rl, input logic md);
        mk = {md, rl, acc, ~pc, ~pw, pa, ~xr, 1'b1, xa, ofr, 1'b0, 1'b0, l0r, l0w, op};
    endfunction

    function automatic void push(input logic [35:0] w, input logic ov, input logic dn);
        exp_t e;
        e.w = w; e.ov = ov; e.dn = dn;
        q.push_back(e);
    endfunction

    task automatic gen(input job_t jb);
        logic [10:0] a;
        q.delete();
        if (jb.nk != 0 && jb.na != 0) begin
            for (int k = 0; k < int'(jb.nk); k++) begin
                if (!jb.md) begin
                    for (int i = 0; i <= 8; i++) begin
                        a = jb.wb + 11'(k * 8 + i);
                        push(mk(2'b00, i >= 1, 0, 0, (i < 8) ? a : 11'd0, i < 8, 0, 0, 0, 0, 0, 0), 1, 0);
                    end
                    for (int i = 0; i < 8; i++)  push(mk(2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0);
                    for (int i = 0; i < 16; i++) push(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0);
                end
                for (int i = 0; i <= int'(jb.na); i++) begin
                    a = jb.xb + 11'(i);
                    push(mk(2'b00, i >= 1, 0, 0, (i < int'(jb.na)) ? a : 11'd0, i < int'(jb.na),
                            0, 0, 0, 0, 0, jb.md), 1, 0);
                end
                for (int i = 0; i < int'(jb.na); i++) push(mk(2'b10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, jb.md), 1, 0);
                if (!jb.md) begin
                    for (int jj = 0; jj < int'(jb.na); jj++) begin
                        if (k == 0 && jj == jb.sj)
                            for (int s = 0; s < jb.sn; s++) push(IW, 0, 0);
                        a = jb.pb + 11'(jj);
                        if (k > 0) push(mk(2'b00, 0, 0, 0, 0, 0, a, 1, 0, 0, 0, 0), 1, 0);
                        push(mk(2'b00, 0, 0, 1, 0, 0, a, 1, 1, k > 0,
                                jb.rl && (k == int'(jb.nk) - 1), 0), 1, 0);
                    end
                end else begin
                    for (int i = 0; i < 16; i++) push(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1, 0);
                end
            end
        end
        push(IW, 1, 1);
    endtask

    task automatic run(input job_t jb);
        exp_t e;
        int   t, dt;
        gen(jb);
        @(negedge clk);
        mode = jb.md; relu = jb.rl; n_kij = jb.nk; n_act = jb.na;
        w_base = jb.wb; x_base = jb.xb; p_base = jb.pb;
        start = 1'b1; ofifo_valid = 1'b1;
        t = 0; dt = -1;
        while (q.size() > 0) begin
            @(negedge clk);
            // a second start with a flipped mode mid-job must be ignored
            start = (t == 10);
            mode  = (t == 10) ? ~jb.md : jb.md;
            e = q.pop_front();
            chk("inst", t, inst, e.w);
            chk("done", t, 36'(done), 36'(e.dn));
            chk("busy", t, 36'(busy), 36'd1);
            if (done && dt < 0) dt = t;
            ofifo_valid = (q.size() > 0) ? q[0].ov : 1'b1;
            t++;
        end
        chk("done_cycle", t, 36'(dt), 36'(jb.exp_len));
        @(negedge clk);
        chk("post_inst", t, inst, IW);
        chk("post_busy", t, 36'(busy), 36'd0);
    endtask

    initial begin
        //           md rl nk na     wb       xb       pb       sj  sn len
        jobs[0] = '{0, 0, 1, 4, 11'h010, 11'h100, 11'h020, -1, 0, 46};
        jobs[1] = '{0, 1, 3, 4, 11'h010, 11'h100, 11'h020, -1, 0, 146};
        jobs[2] = '{0, 0, 1, 4, 11'h010, 11'h100, 11'h020,  2, 5, 51};
        jobs[3] = '{0, 0, 1, 2, 11'h7FC, 11'h7FF, 11'h7FF, -1, 0, 40};
        jobs[4] = '{1, 0, 1, 3, 11'h010, 11'h100, 11'h020, -1, 0, 23};
        jobs[5] = '{1, 0, 2, 0, 11'h010, 11'h100, 11'h020, -1, 0, 0};
        jobs[6] = '{0, 1, 0, 5, 11'h010, 11'h100, 11'h020, -1, 0, 0};
        jobs[7] = '{0, 1, 2, 3, 11'h040, 11'h200, 11'h300,  1, 3, 92};

        reset = 1'b1; start = 1'b1; mode = 0; relu = 0; ofifo_valid = 1'b1;
        n_kij = 4'd1; n_act = 11'd4; w_base = 0; x_base = 0; p_base = 0;
        repeat (2) @(negedge clk);
        chk("rst_inst", 0, inst, IW);
        chk("rst_busy", 0, 36'(busy), 36'd0);
        chk("rst_done", 0, 36'(done), 36'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_ignored", 0, 36'(busy), 36'd0);

        for (int n = 0; n < 8; n++) run(jobs[n]);

        // reset in the middle of EXEC, with start held high
        n_kij = 4'd1; n_act = 11'd4; w_base = 11'h010; x_base = 11'h100; p_base = 11'h020;
        mode = 0; relu = 0; ofifo_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        chk("mid_exec", 39, inst, mk(2'b10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1; start = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("mid_rst_inst", c, inst, IW);
            chk("mid_rst_busy", c, 36'(busy), 36'd0);
            chk("mid_rst_done", c, 36'(done), 36'd0);
        end
        reset = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        chk("after_rst_inst", 0, inst, IW);
        chk("after_rst_busy", 0, 36'(busy), 36'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/core_seq.md
# core_seq

Autonomous instruction sequencer for the systolic core. It replaces testbench-driven instruction streams: given base addresses and pass counts, it emits the 36-bit core instruction word cycle by cycle to run multi-pass weight-stationary convolution with psum accumulation, or an output-stationary pass. It sits directly in front of `core`, drives its `inst` input and watches `ofifo_valid`.

## Interface
- `row`, default 8: PE rows; sets the flush length.
- `col`, default 8: PE columns; sets weight vectors per pass and the flush length.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch request; sampled only in IDLE.
- `mode`  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS); latched on start.
- `relu`  in  1  apply ReLU on the final pass; latched on start.
- `n_kij`  in  4  number of kernel passes, 0..15; latched.
- `n_act`  in  11  activation vectors per pass, 0..2047; latched.
- `w_base`, `x_base`  in  11 each  xmem base addresses for weights and activations; latched.
- `p_base`  in  11  pmem base address for psums; latched.
- `ofifo_valid`  in  1  from core.
- `inst`  out  36  core instruction word, registered.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on job completion.

## Operation
- Instruction fields:
  - [1:0] is 01 = kernel load, 10 = execute, 00 = none.
  - [2] l0_wr, [3] l0_rd, [4] ififo_rd, [5] ififo_wr, [6] ofifo_rd.
  - [17:7] xmem A, [18] xmem WEN, [19] xmem CEN (both active-low).
  - [30:20] pmem A, [31] pmem WEN, [32] pmem CEN (both active-low).
  - [33] accumulate, [34] relu, [35] mode.
- IDLE word: CEN=WEN=1 on both memories, all other bits 0, giving 36'h1_800C_0000. This word is emitted in IDLE, DONE and every stall cycle.
- States: IDLE, W_RD, W_LD, W_FL, X_RD, EXEC, DRAIN, DONE. A pass counter k counts 0..n_kij-1 and an index counter i is used within each state.
- W_RD (WS only), col+1 cycles:
  - Cycle i<col: xmem read, A = w_base + k·col + i.
  - Cycles i≥1: l0_wr=1, covering the 1-cycle SRAM latency.
- W_LD, col cycles: l0_rd=1, [1:0]=01.
- W_FL, row+col cycles: [1:0]=00, no reads. This lets the weights settle.
- X_RD, n_act+1 cycles: same pattern as W_RD, with A = x_base + i.
- EXEC, n_act cycles: l0_rd=1, [1:0]=10.
- DRAIN (WS), handles n_act outputs j; each output waits for ofifo_valid=1.
  - If k=0: one write cycle with ofifo_rd=1, pmem CEN=0 WEN=0, A = p_base + j, accumulate=0.
  - If k>0: first a pmem read cycle (CEN=0 WEN=1, A = p_base + j), then the write cycle above with accumulate=1.
  - relu bit = latched relu AND (k = n_kij-1), asserted on write cycles only.
- End of pass: if k < n_kij-1, increment k and go to W_RD; otherwise go to DONE.
- OS mode:
  - W_RD, W_LD and W_FL are skipped.
  - After EXEC, a row+col cycle flush replaces DRAIN.
  - inst[35]=1 throughout the job.
- All address arithmetic is 11-bit modulo 2048, so addresses wrap.

## Timing
- Reset response: on the cycle after reset is asserted, state=IDLE, inst=36'h1_800C_0000, busy=0, done=0, counters 0. Reset overrides all other inputs in any state, including mid-pass.
- start:
  - Seen in IDLE: the first W_RD (or X_RD in OS) word appears on the next cycle and busy rises on that same cycle.
  - Ignored while busy.
- Degenerate job: if n_kij=0 or n_act=0, go IDLE→DONE→IDLE with no memory or FIFO activity; done is high for one cycle.
- DONE lasts one cycle: done=1, busy=1. Next cycle is IDLE with busy=0, and start is accepted there.
- WS pass length without stalls: (col+1) + col + (row+col) + (n_act+1) + n_act + drain. Drain is n_act cycles for k=0 and 2·n_act cycles for k>0.
- ofifo_valid low in DRAIN: emit the idle word with no read issued, then resume at the same j. A read/write pair is never split; once the read cycle is issued, the write follows on the next cycle.
- inst changes only on rising edges and has no combinational path from any input.

## Test plan
- Reset: assert reset for 2 cycles during EXEC → next cycle inst=36'h1_800C_0000, busy=0; a start held during reset is ignored.
- Single WS pass: n_kij=1, n_act=4, w_base=0x010, x_base=0x100, p_base=0x020, ofifo_valid=1 → the following sequence, then a done pulse:
  - xmem reads 0x010–0x017, with l0_wr lagging by 1;
  - 8 load cycles, then 16 flush cycles;
  - xmem reads 0x100–0x103;
  - 4 execute cycles;
  - pmem writes 0x020–0x023 with accumulate=0.
- Three WS passes, relu=1: second-pass weight reads start at 0x018 → on passes 2–3, read/write pairs to 0x020–0x023 with accumulate=1; relu=1 only on pass-3 writes.
- Drain stall: hold ofifo_valid low for 5 cycles before j=2 → 5 idle words, no pmem access, then j=2 resumes.
- Wrap: w_base=0x7FC, col=8 → reads 0x7FC–0x7FF, then 0x000–0x003.
- OS and degenerate: mode=1, n_act=3 → no weight phase, inst[35]=1, no pmem writes, 16-cycle flush then done. Then n_act=0 → done on the cycle after start.
